uncache_store_buffer: RTL and testbench



---
 rtl/uncache_store_buffer.sv | 219 +++++++++++++++++++++
 tb/tb_uncache_store_buffer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_store_buffer.sv
// uncache_store_buffer
//   Queues committed uncached stores in a small FIFO and drains them one at a time to the AXI
//   bridge's uncache port. Uncached loads are serialised behind every older store so MMIO
//   ordering is preserved. A pipeline stall is raised while a load is outstanding or while a
//   store is presented to a full FIFO.
//
//   Optional feature: define UNCACHE_PERF_EN to add three 32-bit wrap-around performance
//   counters (perf_wr_cnt, perf_rd_cnt, perf_full_cnt). Functional behaviour is unchanged.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   st_*              store request from pipeline (st_ready is combinational)
//   ld_*              load request (held until ld_done), result and one-cycle done pulse
//   stall_req         pipeline stall
//   uncache_*         registered request to bridge; uncache_refresh is the completion pulse
//   perf_*            performance counters (UNCACHE_PERF_EN only)
module uncache_store_buffer #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PTR_W = 2
) (
   input  logic              clk,
   input  logic              rst,
`ifdef UNCACHE_PERF_EN
   output logic [31:0]       perf_wr_cnt,
   output logic [31:0]       perf_rd_cnt,
   output logic [31:0]       perf_full_cnt,
`endif
   input  logic              st_valid,
   output logic              st_ready,
   input  logic [3:0]        st_wen,
   input  logic [31:0]       st_addr,
   input  logic [31:0]       st_wdata,
   input  logic              ld_valid,
   input  logic [31:0]       ld_addr,
   output logic [31:0]       ld_rdata,
   output logic              ld_done,
   output logic              stall_req,
   output logic              uncache_en,
   output logic [3:0]        uncache_wen,
   output logic [31:0]       uncache_addr,
   output logic [31:0]       uncache_wdata,
   input  logic [31:0]       uncache_rdata,
   input  logic              uncache_refresh
);

   localparam logic [PTR_W:0] CountFull = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W:0] CountOne  = (PTR_W + 1)'(1);

   typedef enum logic [1:0] {StIdle, StWrWait, StRdWait} state_e;

   state_e             state_q, state_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]     count_q, count_d;

   logic [3:0]         mem_wen_q   [DEPTH];
   logic [31:0]        mem_addr_q  [DEPTH];
   logic [31:0]        mem_wdata_q [DEPTH];

   logic               en_q, en_d;
   logic [3:0]         wen_q, wen_d;
   logic [31:0]        addr_q, addr_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        ld_rdata_q, ld_rdata_d;
   logic               ld_done_q, ld_done_d;

   logic               ld_pending;
   logic               push;
   logic               pop;
   logic [PTR_W-1:0]   rd_ptr_nxt;

   // ld_done masks the still-held ld_valid so the finished load is not reissued.
   assign ld_pending = ld_valid && !ld_done_q;
   assign st_ready   = (count_q != CountFull) && !ld_pending;
   assign stall_req  = ld_pending || (st_valid && (count_q == CountFull));
   // A zero-byte-enable store is handshaken but never occupies an entry.
   assign push       = st_valid && st_ready && (st_wen != 4'h0);
   assign pop        = (state_q == StWrWait) && uncache_refresh;
   assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_nxt : rd_ptr_q;
      count_d  = count_q;
      if (push && !pop) begin
         count_d = count_q + CountOne;
      end else if (pop && !push) begin
         count_d = count_q - CountOne;
      end
   end

   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      wen_d      = wen_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ld_rdata_d = ld_rdata_q;
      ld_done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // Stores always drain before a waiting load.
            if (count_q != '0) begin
               en_d    = 1'b1;
               wen_d   = mem_wen_q[rd_ptr_q];
               addr_d  = mem_addr_q[rd_ptr_q];
               wdata_d = mem_wdata_q[rd_ptr_q];
               state_d = StWrWait;
            end else if (ld_pending) begin
               en_d    = 1'b1;
               wen_d   = 4'h0;
               addr_d  = ld_addr;
               wdata_d = 32'h0;
               state_d = StRdWait;
            end
         end
         StWrWait: begin
            if (uncache_refresh) begin
               if (count_q > CountOne) begin
                  wen_d   = mem_wen_q[rd_ptr_nxt];
                  addr_d  = mem_addr_q[rd_ptr_nxt];
                  wdata_d = mem_wdata_q[rd_ptr_nxt];
               end else if (push) begin
                  // Entry being pushed on this edge becomes the new head; forward it.
                  wen_d   = st_wen;
                  addr_d  = st_addr;
                  wdata_d = st_wdata;
               end else begin
                  en_d    = 1'b0;
                  state_d = StIdle;
               end
            end
         end
         StRdWait: begin
            if (uncache_refresh) begin
               ld_rdata_d = uncache_rdata;
               ld_done_d  = 1'b1;
               en_d       = 1'b0;
               state_d    = StIdle;
            end
         end
         default: begin
            en_d    = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         en_q       <= 1'b0;
         wen_q      <= 4'h0;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         ld_rdata_q <= 32'h0;
         ld_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         en_q       <= en_d;
         wen_q      <= wen_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ld_rdata_q <= ld_rdata_d;
         ld_done_q  <= ld_done_d;
      end
   end

   // Storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem_wen_q[wr_ptr_q]   <= st_wen;
         mem_addr_q[wr_ptr_q]  <= st_addr;
         mem_wdata_q[wr_ptr_q] <= st_wdata;
      end
   end

   assign uncache_en    = en_q;
   assign uncache_wen   = wen_q;
   assign uncache_addr  = addr_q;
   assign uncache_wdata = wdata_q;
   assign ld_rdata      = ld_rdata_q;
   assign ld_done       = ld_done_q;

`ifdef UNCACHE_PERF_EN
   logic [31:0] perf_wr_q, perf_wr_d;
   logic [31:0] perf_rd_q, perf_rd_d;
   logic [31:0] perf_full_q, perf_full_d;

   always_comb begin
      perf_wr_d   = perf_wr_q + (pop ? 32'd1 : 32'd0);
      perf_rd_d   = perf_rd_q + (ld_done_q ? 32'd1 : 32'd0);
      perf_full_d = perf_full_q + ((st_valid && (count_q == CountFull)) ? 32'd1 : 32'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_wr_q   <= 32'h0;
         perf_rd_q   <= 32'h0;
         perf_full_q <= 32'h0;
      end else begin
         perf_wr_q   <= perf_wr_d;
         perf_rd_q   <= perf_rd_d;
         perf_full_q <= perf_full_d;
      end
   end

   assign perf_wr_cnt   = perf_wr_q;
   assign perf_rd_cnt   = perf_rd_q;
   assign perf_full_cnt = perf_full_q;
`endif

endmodule

// File: tb/tb_uncache_store_buffer.sv
// Bench for uncache_store_buffer: a bridge model answers every request after a random or fixed
// latency and compares each issued request against an in-order queue of expected transactions
// built from the accepted stores and loads. FIFO occupancy is modelled as accepted stores minus
// completed write refreshes.
module tb_uncache_store_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st_valid = 1'b0;
   logic        st_ready;
   logic [3:0]  st_wen = 4'h0;
   logic [31:0] st_addr = 32'h0;
   logic [31:0] st_wdata = 32'h0;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = 32'h0;
   logic [31:0] ld_rdata;
   logic        ld_done;
   logic        stall_req;
   logic        uncache_en;
   logic [3:0]  uncache_wen;
   logic [31:0] uncache_addr;
   logic [31:0] uncache_wdata;
   logic [31:0] uncache_rdata = 32'h0;
   logic        uncache_refresh = 1'b0;
`ifdef UNCACHE_PERF_EN
   logic [31:0] perf_wr_cnt;
   logic [31:0] perf_rd_cnt;
   logic [31:0] perf_full_cnt;
`endif

   always #5 clk = ~clk;

   uncache_store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
      .clk             (clk),
      .rst             (rst),
`ifdef UNCACHE_PERF_EN
      .perf_wr_cnt     (perf_wr_cnt),
      .perf_rd_cnt     (perf_rd_cnt),
      .perf_full_cnt   (perf_full_cnt),
`endif
      .st_valid        (st_valid),
      .st_ready        (st_ready),
      .st_wen          (st_wen),
      .st_addr         (st_addr),
      .st_wdata        (st_wdata),
      .ld_valid        (ld_valid),
      .ld_addr         (ld_addr),
      .ld_rdata        (ld_rdata),
      .ld_done         (ld_done),
      .stall_req       (stall_req),
      .uncache_en      (uncache_en),
      .uncache_wen     (uncache_wen),
      .uncache_addr    (uncache_addr),
      .uncache_wdata   (uncache_wdata),
      .uncache_rdata   (uncache_rdata),
      .uncache_refresh (uncache_refresh)
   );

   typedef struct packed {
      logic [3:0]  wen;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   int          errors = 0;
   int          checks = 0;
   txn_t        exp_q[$];
   int          wr_acc = 0;       // non-zero-wen stores accepted since reset
   int          wr_done = 0;      // write refreshes since reset
   int          ld_cnt = 0;       // completed loads since reset
   int          full_cycles = 0;  // cycles with st_valid while the model FIFO is full
   int          unstable = 0;
   int          fixed_lat = 0;
   logic [31:0] rd_data_next = 32'h0;

   // Bridge model
   initial begin : bridge
      txn_t cap;
      txn_t e;
      int   lat;
      bit   aborted;
      forever begin
         @(posedge clk); #2;
         if (!rst && uncache_en) begin
            cap = '{uncache_wen, uncache_addr, uncache_wdata};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL bridge_txn: got wen=%h addr=%h wdata=%h, required no request",
                        cap.wen, cap.addr, cap.wdata);
            end else begin
               e = exp_q.pop_front();
               if (cap !== e) begin
                  errors++;
                  $display("FAIL bridge_txn: got wen=%h addr=%h wdata=%h, required %h %h %h",
                           cap.wen, cap.addr, cap.wdata, e.wen, e.addr, e.wdata);
               end
            end
            lat = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(2, 4));
            aborted = 1'b0;
            for (int k = 0; k < lat; k++) begin
               @(posedge clk); #2;
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               if (uncache_en !== 1'b1 || uncache_wen !== cap.wen || uncache_addr !== cap.addr ||
                   uncache_wdata !== cap.wdata) unstable++;
            end
            if (!aborted) begin
               uncache_rdata   = (cap.wen == 4'h0) ? rd_data_next : $urandom;
               uncache_refresh = 1'b1;
               @(posedge clk); #2;
               uncache_refresh = 1'b0;
               if (cap.wen != 4'h0) begin
                  wr_done++;
                  if (wr_acc - wr_done > 0) begin
                     checks++;
                     if (uncache_en !== 1'b1) begin
                        errors++;
                        $display("FAIL back_to_back_en: got en=%b, required 1", uncache_en);
                     end
                  end
               end
            end
         end
      end
   end

   task automatic model_reset();
      exp_q.delete();
      wr_acc = 0;
      wr_done = 0;
      ld_cnt = 0;
      full_cycles = 0;
   endtask

   task automatic do_store(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] data);
      bit acc = 1'b0;
      bit full;
      st_valid = 1'b1;
      st_wen   = wen;
      st_addr  = addr;
      st_wdata = data;
      for (int c = 0; c < 100 && !acc; c++) begin
         @(negedge clk);
         full = ((wr_acc - wr_done) == DEPTH);
         checks++;
         if (st_ready !== !full) begin
            errors++;
            $display("FAIL st_ready: got %b, required %b", st_ready, !full);
         end
         checks++;
         if (stall_req !== full) begin
            errors++;
            $display("FAIL stall_req_store: got %b, required %b", stall_req, full);
         end
         if (full) full_cycles++;
         if (st_ready === 1'b1) begin
            if (wen != 4'h0) begin
               exp_q.push_back('{wen, addr, data});
               wr_acc++;
            end
            acc = 1'b1;
         end
         @(posedge clk); #1;
      end
      st_valid = 1'b0;
      if (!acc) begin
         errors++;
         $display("FAIL store_accept_timeout: got no st_ready, required acceptance");
      end
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [31:0] rdata);
      bit got = 1'b0;
      rd_data_next = rdata;
      exp_q.push_back('{4'h0, addr, 32'h0});
      ld_valid = 1'b1;
      ld_addr  = addr;
      for (int c = 0; c < 300 && !got; c++) begin
         @(negedge clk);
         if (ld_done === 1'b1) begin
            got = 1'b1;
            ld_cnt++;
            checks++;
            if (ld_rdata !== rdata) begin
               errors++;
               $display("FAIL ld_rdata: got %h, required %h", ld_rdata, rdata);
            end
            checks++;
            if (stall_req !== 1'b0) begin
               errors++;
               $display("FAIL stall_on_done: got %b, required 0", stall_req);
            end
         end else begin
            checks++;
            if (stall_req !== 1'b1 || st_ready !== 1'b0) begin
               errors++;
               $display("FAIL load_stall: got stall=%b ready=%b, required 1 0",
                        stall_req, st_ready);
            end
         end
         @(posedge clk); #1;
      end
      ld_valid = 1'b0;
      if (!got) begin
         errors++;
         $display("FAIL load_timeout: got no ld_done, required one");
      end
      @(negedge clk);
      checks++;
      if (ld_done !== 1'b0) begin
         errors++;
         $display("FAIL ld_done_pulse: got %b one cycle later, required 0", ld_done);
      end
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 400 && !ok; c++) begin
         @(negedge clk);
         if (wr_acc == wr_done && uncache_en === 1'b0 && uncache_refresh === 1'b0) ok = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({uncache_en, uncache_wen, uncache_addr, uncache_wdata} !== 69'h0) begin
         errors++;
         $display("FAIL reset_uncache: got en=%b wen=%h addr=%h wdata=%h, required all 0",
                  uncache_en, uncache_wen, uncache_addr, uncache_wdata);
      end
      checks++;
      if (ld_rdata !== 32'h0 || ld_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_load: got rdata=%h done=%b, required 0 0", ld_rdata, ld_done);
      end
      checks++;
      if (st_ready !== 1'b1 || stall_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_handshake: got ready=%b stall=%b, required 1 0",
                  st_ready, stall_req);
      end
`ifdef UNCACHE_PERF_EN
      checks++;
      if ({perf_wr_cnt, perf_rd_cnt, perf_full_cnt} !== 96'h0) begin
         errors++;
         $display("FAIL reset_perf: got %0d %0d %0d, required 0 0 0",
                  perf_wr_cnt, perf_rd_cnt, perf_full_cnt);
      end
`endif
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single_store();
      bit ok;
      do_store(4'hF, 32'hBFAF_8000, 32'h1234_5678);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (uncache_en !== 1'b1 || uncache_wen !== 4'hF || uncache_addr !== 32'hBFAF_8000 ||
          uncache_wdata !== 32'h1234_5678) begin
         errors++;
         $display("FAIL single_issue: got en=%b wen=%h addr=%h wdata=%h, required 1 f bfaf8000 12345678",
                  uncache_en, uncache_wen, uncache_addr, uncache_wdata);
      end
      wait_idle(ok);
      checks++;
      if (!ok || uncache_en !== 1'b0 || st_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_drain: got idle=%b en=%b ready=%b, required 1 0 1",
                  ok, uncache_en, st_ready);
      end
   endtask

   task automatic test_zero_wen();
      int en_seen = 0;
      do_store(4'h0, $urandom, $urandom);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (uncache_en !== 1'b0) en_seen++;
      end
      checks++;
      if (en_seen != 0 || st_ready !== 1'b1) begin
         errors++;
         $display("FAIL zero_wen: got en cycles=%0d ready=%b, required 0 1", en_seen, st_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_burst();
      bit ok;
      int fc0 = full_cycles;
      fixed_lat = 3;
      for (int i = 0; i < 5; i++) do_store(4'($urandom_range(1, 15)), $urandom, $urandom);
      wait_idle(ok);
      fixed_lat = 0;
      checks++;
      if (!ok || exp_q.size() != 0) begin
         errors++;
         $display("FAIL burst_drain: got idle=%b pending=%0d, required 1 0", ok, exp_q.size());
      end
      checks++;
      if (full_cycles <= fc0) begin
         errors++;
         $display("FAIL burst_full: got %0d full cycles, required >0", full_cycles - fc0);
      end
   endtask

   task automatic test_store_then_load();
      bit ok;
      do_store(4'hF, $urandom, $urandom);
      do_load(32'hBFD0_0010, 32'hDEAD_BEEF);
      wait_idle(ok);
      checks++;
      if (!ok || exp_q.size() != 0) begin
         errors++;
         $display("FAIL store_load_order: got idle=%b pending=%0d, required 1 0", ok, exp_q.size());
      end
   endtask

   task automatic test_perf();
`ifdef UNCACHE_PERF_EN
      checks++;
      if (perf_wr_cnt !== 32'(wr_done) || perf_rd_cnt !== 32'(ld_cnt) ||
          perf_full_cnt !== 32'(full_cycles)) begin
         errors++;
         $display("FAIL perf: got wr=%0d rd=%0d full=%0d, required %0d %0d %0d",
                  perf_wr_cnt, perf_rd_cnt, perf_full_cnt, wr_done, ld_cnt, full_cycles);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int en_seen = 0;
      fixed_lat = 6;
      for (int i = 0; i < 3; i++) do_store(4'hF, $urandom, $urandom);
      @(negedge clk);
      checks++;
      if (uncache_en !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_pre: got en=%b, required 1", uncache_en);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (uncache_en !== 1'b0 || st_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: got en=%b ready=%b, required 0 1", uncache_en, st_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      fixed_lat = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (uncache_en !== 1'b0) en_seen++;
      end
      checks++;
      if (en_seen != 0) begin
         errors++;
         $display("FAIL reset_stale: got %0d en cycles, required 0", en_seen);
      end
`ifdef UNCACHE_PERF_EN
      checks++;
      if (perf_wr_cnt !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_perf: got %0d, required 0", perf_wr_cnt);
      end
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      bit ok;
      int r;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 6) begin
            do_store(4'($urandom_range(0, 15)), $urandom, $urandom);
         end else if (r == 7) begin
            do_load({$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, $urandom);
         end else begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      wait_idle(ok);
      checks++;
      if (!ok || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_drain: got idle=%b pending=%0d, required 1 0", ok, exp_q.size());
      end
      checks++;
      if (unstable != 0) begin
         errors++;
         $display("FAIL output_stability: got %0d unstable cycles, required 0", unstable);
      end
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got no finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin : main
      test_reset();
      test_single_store();
      test_zero_wen();
      test_burst();
      test_store_then_load();
      test_perf();
      test_reset_mid();
      test_random();
      test_perf();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
